// File: rtl/dedisp_pkg.sv
// Shared definitions for the dedispersed-power integrator/trigger: FSM encodings,
// a constant-function clog2 and saturating-add helpers.
package dedisp_pkg;

    localparam logic       FRM_IDLE   = 1'b0;
    localparam logic       FRM_ACCUM  = 1'b1;

    localparam logic [1:0] TRG_WARMUP = 2'd0;
    localparam logic [1:0] TRG_ARMED  = 2'd1;
    localparam logic [1:0] TRG_HOLD   = 2'd2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Unsigned add clamped to 2^width-1; operands are zero-extended to 64 bits by the caller.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int width);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << width) - 65'd1;
        return (sum > lim) ? 64'(lim) : 64'(sum);
    endfunction

    function automatic logic sat_ovf(input logic [63:0] a, input logic [63:0] b,
                                     input int width);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << width) - 65'd1;
        return (sum > lim);
    endfunction

endpackage

// File: rtl/dedisp_ema_baseline.sv
// Exponential moving-average baseline: loads the first eligible frame directly, then
// moves 2^-AVG_SHIFT of the way towards each eligible frame, clamped to the unsigned range.
module dedisp_ema_baseline #(
    parameter int DOUT_WIDTH = 32,
    parameter int AVG_SHIFT  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  sample_valid,
    input  logic                  is_trigger,
    input  logic                  is_sat,
    input  logic [DOUT_WIDTH-1:0] integ,
    output logic [DOUT_WIDTH-1:0] baseline
);

    logic [DOUT_WIDTH-1:0]        base_q, base_d;
    logic                         loaded_q, loaded_d;
    logic                         update;
    logic signed [DOUT_WIDTH+1:0] diff_s, step_s, next_s;
    logic [DOUT_WIDTH-1:0]        ema_clamped;

    always_comb begin
        diff_s = $signed({2'b00, integ}) - $signed({2'b00, base_q});
        step_s = diff_s >>> AVG_SHIFT;
        next_s = $signed({2'b00, base_q}) + step_s;
        if (next_s[DOUT_WIDTH+1]) begin
            ema_clamped = '0;
        end else if (next_s[DOUT_WIDTH]) begin
            ema_clamped = '1;
        end else begin
            ema_clamped = next_s[DOUT_WIDTH-1:0];
        end
    end

    // Trigger and saturated frames would drag the baseline towards the event itself.
    assign update = sample_valid && !is_trigger && !is_sat;

    always_comb begin
        base_d   = base_q;
        loaded_d = loaded_q;
        if (update) begin
            loaded_d = 1'b1;
            base_d   = loaded_q ? ema_clamped : integ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q   <= '0;
            loaded_q <= 1'b0;
        end else if (ce) begin
            base_q   <= base_d;
            loaded_q <= loaded_d;
        end
    end

    assign baseline = base_q;

endmodule

// File: rtl/dedisp_integ_trigger.sv
// Frame integrator and burst trigger for the dedispersed power stream.
// Optional build macro DEDISP_TRIG_STAMP_EN adds the trig_stamp good-frame timestamp port.
module dedisp_integ_trigger
    import dedisp_pkg::*;
#(
    parameter int N_CHANNELS = 64,
    parameter int DIN_WIDTH  = 25,
    parameter int DOUT_WIDTH = 32,
    parameter int AVG_SHIFT  = 4,
    parameter int HOLDOFF    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic                  din_valid,
    input  logic                  din_sof,
    input  logic                  din_eof,
    input  logic [DOUT_WIDTH-1:0] thresh,
    output logic [DOUT_WIDTH-1:0] integ_pow,
    output logic                  integ_valid,
    output logic                  integ_sat,
    output logic [DOUT_WIDTH-1:0] baseline,
    output logic                  trigger,
    output logic                  frame_err
`ifdef DEDISP_TRIG_STAMP_EN
    ,
    output logic [31:0]           trig_stamp
`endif
);

    localparam int CNT_W  = clog2(N_CHANNELS + 2);
    localparam int HOLD_W = clog2(HOLDOFF + 2);
    localparam int WARM_W = AVG_SHIFT + 1;

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(N_CHANNELS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((1 << AVG_SHIFT) - 1);
    localparam logic [WARM_W-1:0] WARM_ONE  = WARM_W'(1);

    // Frame stage
    logic                  frm_state_q, frm_state_d;
    logic [DOUT_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [DOUT_WIDTH-1:0] integ_pow_q, integ_pow_d;
    logic                  integ_valid_q, integ_valid_d;
    logic                  integ_sat_q, integ_sat_d;
    logic                  frame_err_q, frame_err_d;

    logic [DOUT_WIDTH-1:0] din_ext;
    logic [DOUT_WIDTH-1:0] acc_sum;
    logic                  acc_ovf;

    // Detection stage
    logic [1:0]            trg_state_q, trg_state_d;
    logic [WARM_W-1:0]     warm_cnt_q, warm_cnt_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic                  trigger_q, trigger_d;
    logic                  hit;
    logic                  fire;
    logic [DOUT_WIDTH-1:0] baseline_w;

    assign din_ext = DOUT_WIDTH'(din);
    assign acc_sum = DOUT_WIDTH'(sat_add(64'(acc_q), 64'(din), DOUT_WIDTH));
    assign acc_ovf = sat_ovf(64'(acc_q), 64'(din), DOUT_WIDTH);

    always_comb begin
        frm_state_d   = frm_state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        ovf_d         = ovf_q;
        integ_pow_d   = integ_pow_q;
        integ_valid_d = 1'b0;
        integ_sat_d   = integ_sat_q;
        frame_err_d   = 1'b0;

        if (din_valid) begin
            // A fresh sof inside an open frame abandons the frame in progress.
            if (frm_state_q == FRM_ACCUM && din_sof) begin
                frame_err_d = 1'b1;
            end

            if (din_sof) begin
                if (din_eof) begin
                    frm_state_d = FRM_IDLE;
                    if (N_CHANNELS == 1) begin
                        integ_pow_d   = din_ext;
                        integ_valid_d = 1'b1;
                        integ_sat_d   = 1'b0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    frm_state_d = FRM_ACCUM;
                    acc_d       = din_ext;
                    cnt_d       = CNT_ONE;
                    ovf_d       = 1'b0;
                end
            end else if (frm_state_q == FRM_ACCUM) begin
                if (cnt_q == CNT_FULL) begin
                    frame_err_d = 1'b1;
                    frm_state_d = FRM_IDLE;
                end else if (din_eof) begin
                    frm_state_d = FRM_IDLE;
                    if (cnt_q + CNT_ONE == CNT_FULL) begin
                        integ_pow_d   = acc_sum;
                        integ_valid_d = 1'b1;
                        integ_sat_d   = ovf_q || acc_ovf;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CNT_ONE;
                    ovf_d = ovf_q || acc_ovf;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frm_state_q   <= FRM_IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            integ_pow_q   <= '0;
            integ_valid_q <= 1'b0;
            integ_sat_q   <= 1'b0;
            frame_err_q   <= 1'b0;
        end else if (ce) begin
            frm_state_q   <= frm_state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            integ_pow_q   <= integ_pow_d;
            integ_valid_q <= integ_valid_d;
            integ_sat_q   <= integ_sat_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // One extra bit on both sides so baseline+thresh cannot wrap.
    assign hit = {1'b0, integ_pow_q} > ({1'b0, baseline_w} + {1'b0, thresh});

    always_comb begin
        trg_state_d = trg_state_q;
        warm_cnt_d  = warm_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        fire        = 1'b0;

        if (integ_valid_q) begin
            case (trg_state_q)
                TRG_WARMUP: begin
                    if (warm_cnt_q == WARM_LAST) begin
                        warm_cnt_d  = '0;
                        trg_state_d = TRG_ARMED;
                    end else begin
                        warm_cnt_d = warm_cnt_q + WARM_ONE;
                    end
                end
                TRG_ARMED: begin
                    if (hit || integ_sat_q) begin
                        fire = 1'b1;
                        if (HOLDOFF != 0) begin
                            hold_cnt_d  = HOLD_LOAD;
                            trg_state_d = TRG_HOLD;
                        end
                    end
                end
                TRG_HOLD: begin
                    hold_cnt_d = hold_cnt_q - HOLD_ONE;
                    if (hold_cnt_q == HOLD_ONE) begin
                        trg_state_d = TRG_ARMED;
                    end
                end
                default: begin
                    trg_state_d = TRG_WARMUP;
                    warm_cnt_d  = '0;
                end
            endcase
        end
        trigger_d = fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trg_state_q <= TRG_WARMUP;
            warm_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            trigger_q   <= 1'b0;
        end else if (ce) begin
            trg_state_q <= trg_state_d;
            warm_cnt_q  <= warm_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            trigger_q   <= trigger_d;
        end
    end

    dedisp_ema_baseline #(
        .DOUT_WIDTH (DOUT_WIDTH),
        .AVG_SHIFT  (AVG_SHIFT)
    ) u_ema (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .sample_valid (integ_valid_q),
        .is_trigger   (fire),
        .is_sat       (integ_sat_q),
        .integ        (integ_pow_q),
        .baseline     (baseline_w)
    );

`ifdef DEDISP_TRIG_STAMP_EN
    logic [31:0] good_cnt_q, good_cnt_d;
    logic [31:0] stamp_q, stamp_d;

    // The good-frame count already includes the triggering frame when fire is evaluated.
    always_comb begin
        good_cnt_d = integ_valid_d ? good_cnt_q + 32'd1 : good_cnt_q;
        stamp_d    = fire ? good_cnt_q : stamp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            good_cnt_q <= '0;
            stamp_q    <= '0;
        end else if (ce) begin
            good_cnt_q <= good_cnt_d;
            stamp_q    <= stamp_d;
        end
    end

    assign trig_stamp = stamp_q;
`endif

    assign integ_pow   = integ_pow_q;
    assign integ_valid = integ_valid_q;
    assign integ_sat   = integ_sat_q;
    assign baseline    = baseline_w;
    assign trigger     = trigger_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_dedisp_integ_trigger.sv
// Self-checking bench for dedisp_integ_trigger: directed frame table, hand-written
// framing/saturation/reset sequences and randomized frames against a frame-level model.
module tb_dedisp_integ_trigger;

    localparam int     N   = 64;
    localparam int     DW  = 25;
    localparam int     OW  = 26;
    localparam int     AS  = 4;
    localparam int     HO  = 16;
    localparam longint MAXV = (longint'(1) << OW) - 1;
    localparam longint DIN_MAX = (longint'(1) << DW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_sof;
    logic          din_eof;
    logic [OW-1:0] thresh;
    logic [OW-1:0] integ_pow;
    logic          integ_valid;
    logic          integ_sat;
    logic [OW-1:0] baseline;
    logic          trigger;
    logic          frame_err;
`ifdef DEDISP_TRIG_STAMP_EN
    logic [31:0]   trig_stamp;
`endif

    dedisp_integ_trigger #(
        .N_CHANNELS (N),
        .DIN_WIDTH  (DW),
        .DOUT_WIDTH (OW),
        .AVG_SHIFT  (AS),
        .HOLDOFF    (HO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .din         (din),
        .din_valid   (din_valid),
        .din_sof     (din_sof),
        .din_eof     (din_eof),
        .thresh      (thresh),
        .integ_pow   (integ_pow),
        .integ_valid (integ_valid),
        .integ_sat   (integ_sat),
        .baseline    (baseline),
        .trigger     (trigger),
        .frame_err   (frame_err)
`ifdef DEDISP_TRIG_STAMP_EN
        ,
        .trig_stamp  (trig_stamp)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Frame-level reference: good-frame index, last trigger index and EMA value.
    longint m_base;
    bit     m_loaded;
    int     m_good;
    int     m_last_trig;

    typedef struct {
        longint val;
        longint thr;
        longint exp_pow;
        bit     exp_trig;
        longint exp_base;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_base      = 0;
        m_loaded    = 0;
        m_good      = 0;
        m_last_trig = 0;
    endtask

    function automatic bit m_eligible(input int idx);
        return (idx > (1 << AS)) && (m_last_trig == 0 || idx - m_last_trig > HO);
    endfunction

    task automatic model_frame(input longint raw, input longint thr, output longint e_pow,
                               output bit e_sat, output bit e_trig, output longint e_base);
        longint d;
        longint w;
        longint q;
        e_sat = (raw > MAXV);
        e_pow = e_sat ? MAXV : raw;
        m_good++;
        e_trig = m_eligible(m_good) && ((e_pow > m_base + thr) || e_sat);
        if (e_trig) begin
            m_last_trig = m_good;
        end else if (!e_sat) begin
            if (!m_loaded) begin
                m_base   = e_pow;
                m_loaded = 1;
            end else begin
                w = longint'(1) << AS;
                d = e_pow - m_base;
                q = (d >= 0) ? d / w : -((-d + w - 1) / w);
                m_base = m_base + q;
                if (m_base < 0) m_base = 0;
            end
        end
        e_base = m_base;
    endtask

    // Optional idle / clock-enable-low cycles, then one qualified sample.
    task automatic drive_sample(input longint v, input bit sof, input bit eof, input int gap_pct);
        int n;
        n = 0;
        while (n < 6 && $urandom_range(99, 0) < gap_pct) begin
            ce        = 1'($urandom_range(1, 0));
            din_valid = ce ? 1'b0 : 1'($urandom_range(1, 0));
            din_sof   = 1'($urandom_range(1, 0));
            din_eof   = 1'($urandom_range(1, 0));
            din       = DW'($urandom);
            tick();
            n++;
        end
        ce        = 1'b1;
        din_valid = 1'b1;
        din_sof   = sof;
        din_eof   = eof;
        din       = DW'(v);
        tick();
        din_valid = 1'b0;
        din_sof   = 1'b0;
        din_eof   = 1'b0;
    endtask

    task automatic send_frame(input int len, input bit sof_first, input bit eof_last,
                              input longint val, input longint rnd_max, input int gap_pct,
                              output longint raw, output int errs);
        longint v;
        raw  = 0;
        errs = 0;
        for (int i = 0; i < len; i++) begin
            v = (rnd_max > 0) ? longint'($urandom_range(32'(rnd_max), 0)) : val;
            raw += v;
            drive_sample(v, sof_first && i == 0, eof_last && i == len - 1, gap_pct);
            errs += int'(frame_err);
        end
    endtask

    // Called at E+1 after a well-formed frame; leaves the bench two cycles later.
    task automatic check_frame(input string tag, input longint raw, input longint thr,
                               output longint got_pow, output bit got_trig,
                               output longint got_base);
        longint e_pow;
        longint e_base;
        bit     e_sat;
        bit     e_trig;
        model_frame(raw, thr, e_pow, e_sat, e_trig, e_base);
        check({tag, "/integ_valid"}, 64'(integ_valid), 64'(1));
        check({tag, "/integ_pow"}, 64'(integ_pow), 64'(e_pow));
        check({tag, "/integ_sat"}, 64'(integ_sat), 64'(e_sat));
        check({tag, "/err_e1"}, 64'(frame_err), 64'(0));
        check({tag, "/trig_e1"}, 64'(trigger), 64'(0));
        got_pow = longint'(integ_pow);
        tick();
        check({tag, "/trigger"}, 64'(trigger), 64'(e_trig));
        check({tag, "/baseline"}, 64'(baseline), 64'(e_base));
        check({tag, "/valid_e2"}, 64'(integ_valid), 64'(0));
`ifdef DEDISP_TRIG_STAMP_EN
        check({tag, "/trig_stamp"}, 64'(trig_stamp), 64'(m_last_trig));
`endif
        got_trig = trigger;
        got_base = longint'(baseline);
        tick();
        $display("frame %s: pow=%0d sat=%0d trig=%0d base=%0d", tag, got_pow, e_sat, got_trig, got_base);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   vecs[34];
        longint raw;
        longint gp;
        longint gb;
        longint base_before;
        longint rmax;
        longint thr;
        bit     gt;
        int     errs;
        int     guard;

        for (int i = 0; i < 34; i++) begin
            if (i < 16)       vecs[i] = '{1, 100, 64, 1'b0, 64};
            else if (i == 16) vecs[i] = '{10, 100, 640, 1'b1, 64};
            else if (i == 17) vecs[i] = '{10, 100, 640, 1'b0, -1};
            else if (i < 33)  vecs[i] = '{1, 100, 64, 1'b0, -1};
            else              vecs[i] = '{10, 100, 640, 1'b1, -1};
        end

        rst = 1'b1; ce = 1'b1; din = '0; din_valid = 1'b0; din_sof = 1'b0; din_eof = 1'b0;
        thresh = '0;
        repeat (3) tick();
        check("rst/integ_pow", 64'(integ_pow), 64'(0));
        check("rst/integ_valid", 64'(integ_valid), 64'(0));
        check("rst/integ_sat", 64'(integ_sat), 64'(0));
        check("rst/baseline", 64'(baseline), 64'(0));
        check("rst/trigger", 64'(trigger), 64'(0));
        check("rst/frame_err", 64'(frame_err), 64'(0));
        rst = 1'b0;
        m_reset();
        tick();

        // Warm-up, first trigger, holdoff and re-arm.
        for (int i = 0; i < 34; i++) begin
            thresh = OW'(vecs[i].thr);
            send_frame(N, 1, 1, vecs[i].val, 0, 0, raw, errs);
            check($sformatf("vec%0d/errs", i), 64'(errs), 64'(0));
            check_frame($sformatf("vec%0d", i), raw, vecs[i].thr, gp, gt, gb);
            check($sformatf("vec%0d/tab_pow", i), 64'(gp), 64'(vecs[i].exp_pow));
            check($sformatf("vec%0d/tab_trig", i), 64'(gt), 64'(vecs[i].exp_trig));
            if (vecs[i].exp_base >= 0)
                check($sformatf("vec%0d/tab_base", i), 64'(gb), 64'(vecs[i].exp_base));
        end

        // Abort by sof at sample 30; the new frame integrates on its own.
        thresh = OW'(100);
        send_frame(29, 1, 0, 3, 0, 0, raw, errs);
        check("abort/no_early_err", 64'(errs), 64'(0));
        send_frame(N, 1, 1, 5, 0, 0, raw, errs);
        check("abort/err_pulses", 64'(errs), 64'(1));
        check_frame("abort_new", raw, 100, gp, gt, gb);
        check("abort_new/pow", 64'(gp), 64'(320));

        // Short frame: error, no result.
        base_before = longint'(baseline);
        send_frame(N - 1, 1, 1, 1, 0, 0, raw, errs);
        check("short/frame_err", 64'(frame_err), 64'(1));
        check("short/integ_valid", 64'(integ_valid), 64'(0));
        tick();
        check("short/err_1cyc", 64'(frame_err), 64'(0));
        check("short/trigger", 64'(trigger), 64'(0));
        tick();

        // Overrun: error on the 65th sample, later sample without sof dropped.
        send_frame(N + 1, 1, 0, 2, 0, 0, raw, errs);
        check("overrun/err_pulses", 64'(errs), 64'(1));
        drive_sample(7, 0, 0, 0);
        check("overrun/drop_quiet", 64'(frame_err), 64'(0));
        tick();

        // Single-sample sof+eof frame.
        drive_sample(4, 1, 1, 0);
        check("single/frame_err", 64'(frame_err), 64'(1));
        check("single/integ_valid", 64'(integ_valid), 64'(0));
        tick();
        tick();
        check("malformed/baseline", 64'(baseline), 64'(base_before));

        // Saturation while armed.
        guard = 0;
        while (!m_eligible(m_good + 1) && guard < 40) begin
            send_frame(N, 1, 1, 1, 0, 0, raw, errs);
            check_frame("rearm", raw, 100, gp, gt, gb);
            guard++;
        end
        base_before = longint'(baseline);
        send_frame(N, 1, 1, DIN_MAX, 0, 0, raw, errs);
        check_frame("sat_armed", raw, 100, gp, gt, gb);
        check("sat_armed/pow", 64'(gp), 64'(MAXV));
        check("sat_armed/trig", 64'(gt), 64'(1));
        check("sat_armed/base", 64'(gb), 64'(base_before));
        send_frame(N, 1, 1, DIN_MAX, 0, 0, raw, errs);
        check_frame("sat_hold", raw, 100, gp, gt, gb);
        check("sat_hold/base", 64'(gb), 64'(base_before));

        // Clock enable toggling mid-frame must not change the result.
        send_frame(N, 1, 1, 7, 0, 50, raw, errs);
        check("ce_toggle/errs", 64'(errs), 64'(0));
        check_frame("ce_toggle", raw, 100, gp, gt, gb);
        check("ce_toggle/pow", 64'(gp), 64'(448));

        // Reset at sample 20 drops the partial frame silently.
        send_frame(19, 1, 0, 9, 0, 0, raw, errs);
        rst = 1'b1;
        drive_sample(9, 0, 0, 0);
        rst = 1'b0;
        m_reset();
        check("midrst/integ_pow", 64'(integ_pow), 64'(0));
        check("midrst/baseline", 64'(baseline), 64'(0));
        check("midrst/integ_valid", 64'(integ_valid), 64'(0));
        check("midrst/integ_sat", 64'(integ_sat), 64'(0));
        check("midrst/trigger", 64'(trigger), 64'(0));
        check("midrst/frame_err", 64'(frame_err), 64'(0));
        send_frame(N - 20, 0, 1, 9, 0, 0, raw, errs);
        check("midrst/tail_errs", 64'(errs), 64'(0));
        check("midrst/tail_valid", 64'(integ_valid), 64'(0));
        tick();
        tick();
        send_frame(N, 1, 1, 10, 0, 0, raw, errs);
        check_frame("post_rst", raw, 100, gp, gt, gb);
        check("post_rst/warmup_trig", 64'(gt), 64'(0));
        check("post_rst/base_load", 64'(gb), 64'(640));

        // Randomized frames against the model.
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(9, 0))
                0:       rmax = DIN_MAX;
                1, 2:    rmax = 100000;
                default: rmax = 2000;
            endcase
            thr = ($urandom_range(3, 0) == 0) ? longint'($urandom_range(1000000, 0))
                                              : longint'($urandom_range(20000, 0));
            thresh = OW'(thr);
            send_frame(N, 1, 1, 0, rmax, int'($urandom_range(40, 0)), raw, errs);
            check($sformatf("rnd%0d/errs", f), 64'(errs), 64'(0));
            check_frame($sformatf("rnd%0d", f), raw, thr, gp, gt, gb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
